dmem_mmio_bridge: RTL and testbench

- Sits directly downstream of the pipelined core's data-memory port and consumes the core's M-stage outputs: address, write data, 2-bit size mask, active-low write enable.
- Splits each access between the data RAM and a small memory-mapped peripheral bank: LEDs, switches, free-running timer, and a FIFO-buffered UART transmitter.
- Read data returns combinationally in the same cycle, because the core has no memory stall.

---
 rtl/dmem_mmio_bridge.sv | 236 +++++++++++++++++++++++
 tb/tb_dmem_mmio_bridge.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge: splits core data-memory accesses between the data RAM and
// a small MMIO bank (LED, switches, timer, FIFO-buffered UART TX).
// Build option: define TIMER_CMP_EN to add the CMP register (0x014) and timer_irq.
// Ports:
//   clk, rst                  core clock, synchronous active-high reset
//   dmem_addr/wdata/mask/wen  core M-stage access (wen active low)
//   dmem_rdata                load data, combinational
//   ram_addr/wdata/mask/we    RAM side passthrough + active-high write strobe
//   ram_rdata                 asynchronous RAM read data
//   sw                        raw board switches
//   led                       LED register
//   uart_tx                   UART serial output, idle high
//   timer_irq                 timer compare interrupt (0 without TIMER_CMP_EN)
module dmem_mmio_bridge #(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LED_W      = 16,
  parameter int unsigned SW_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dmem_addr,
  input  logic [31:0]       dmem_wdata,
  input  logic [1:0]        mask,
  input  logic              dmem_wen,
  output logic [31:0]       dmem_rdata,
  output logic [31:0]       ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [1:0]        ram_mask,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led,
  output logic              uart_tx,
  output logic              timer_irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = 16;

  localparam logic [11:0] OFF_LED   = 12'h000;
  localparam logic [11:0] OFF_SW    = 12'h004;
  localparam logic [11:0] OFF_TIMER = 12'h008;
  localparam logic [11:0] OFF_UDATA = 12'h00C;
  localparam logic [11:0] OFF_STAT  = 12'h010;
`ifdef TIMER_CMP_EN
  localparam logic [11:0] OFF_CMP   = 12'h014;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_e;

  // Region decode and RAM passthrough
  logic        mmio;
  logic        wr;
  logic [11:0] off;

  assign mmio      = (dmem_addr[31:12] == 20'hFFFFF);
  assign wr        = mmio && !dmem_wen;
  assign off       = dmem_addr[11:0];
  assign ram_addr  = dmem_addr;
  assign ram_wdata = dmem_wdata;
  assign ram_mask  = mask;
  assign ram_we    = !dmem_wen && !mmio;

  // LED, switch synchroniser, timer
  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
  logic [31:0]      timer_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      timer_q <= '0;
    end else begin
      if (wr && off == OFF_LED) led_q <= dmem_wdata[LED_W-1:0];
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
      // A write beat still counts, so the loaded value is visible already incremented
      timer_q <= (wr && off == OFF_TIMER) ? dmem_wdata + 32'd1 : timer_q + 32'd1;
    end
  end

  assign led = led_q;

  // UART TX FIFO; count derives from the extra pointer bit
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q, count;
  logic          full, empty, push, drop, pop, ovf_q;
  tx_state_e     state_q, state_d;

  assign count = wptr_q - rptr_q;
  assign full  = (count == PW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = wr && off == OFF_UDATA && !full;
  assign drop  = wr && off == OFF_UDATA && full;
  assign pop   = (state_q == ST_IDLE) && !empty;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q[AW-1:0]] <= dmem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      // Overflow set takes priority over a clearing STAT write
      if (drop)                          ovf_q <= 1'b1;
      else if (wr && off == OFF_STAT)    ovf_q <= 1'b0;
    end
  end

  // TX FSM: state register
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_end;

  assign baud_end = (cnt_q == CW'(BAUD_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // TX FSM: next state; line level is registered from the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d = ST_START;
          cnt_d   = '0;
          shift_d = fifo_q[rptr_q[AW-1:0]];
        end
      end
      ST_START: begin
        if (baud_end) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign uart_tx = tx_q;

`ifdef TIMER_CMP_EN
  // Timer compare: sticky level, set has priority over the CMP-write clear
  logic [31:0] cmp_q;
  logic        irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q <= 32'hFFFF_FFFF;
      irq_q <= 1'b0;
    end else begin
      if (wr && off == OFF_CMP) cmp_q <= dmem_wdata;
      if (timer_q == cmp_q)           irq_q <= 1'b1;
      else if (wr && off == OFF_CMP)  irq_q <= 1'b0;
    end
  end

  assign timer_irq = irq_q;
`else
  assign timer_irq = 1'b0;
`endif

  // Load data mux
  logic [31:0] mmio_rdata;

  always_comb begin
    mmio_rdata = '0;
    case (off)
      OFF_LED:   mmio_rdata = 32'(led_q);
      OFF_SW:    mmio_rdata = 32'(sw_s2_q);
      OFF_TIMER: mmio_rdata = timer_q;
      OFF_STAT:  mmio_rdata = {21'd0, 7'(count), ovf_q, (state_q != ST_IDLE), empty, full};
`ifdef TIMER_CMP_EN
      OFF_CMP:   mmio_rdata = cmp_q;
`endif
      default:   mmio_rdata = '0;
    endcase
    dmem_rdata = mmio ? mmio_rdata : ram_rdata;
  end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Testbench for dmem_mmio_bridge (BAUD_DIV=4, FIFO_DEPTH=8): decode table,
// directed multi-cycle sequences, and randomized accesses against a
// behavioural model of the LED/switch/timer registers.
module tb_dmem_mmio_bridge;

  localparam int unsigned BAUD  = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = 16;
  localparam int unsigned SWW   = 16;
  localparam logic [31:0] MM    = 32'hFFFF_F000;

  logic           clk = 1'b0;
  logic           rst;
  logic [31:0]    dmem_addr, dmem_wdata, dmem_rdata;
  logic [1:0]     mask;
  logic           dmem_wen;
  logic [31:0]    ram_addr, ram_wdata, ram_rdata;
  logic [1:0]     ram_mask;
  logic           ram_we;
  logic [SWW-1:0] sw;
  logic [LW-1:0]  led;
  logic           uart_tx, timer_irq;

  dmem_mmio_bridge #(
    .BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH), .LED_W(LW), .SW_W(SWW)
  ) dut (
    .clk(clk), .rst(rst),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .mask(mask), .dmem_wen(dmem_wen),
    .dmem_rdata(dmem_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_mask(ram_mask), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .sw(sw), .led(led), .uart_tx(uart_tx), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stat_word(input int full, input int empty, input int busy,
                                            input int ovf, input int cnt);
    return 32'(full + 2 * empty + 4 * busy + 8 * ovf + 16 * cnt);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dmem_addr  = MM | 32'h010;
    dmem_wdata = '0;
    dmem_wen   = 1'b1;
    mask       = 2'b10;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic mmio_write(input logic [11:0] off, input logic [31:0] data);
    dmem_addr  = MM | 32'(off);
    dmem_wdata = data;
    dmem_wen   = 1'b0;
    tick();
    idle();
  endtask

  // Line capture for offline frame decoding
  logic txlog [$];
  bit   cap_en = 1'b0;
  always @(posedge clk) begin
    #1;
    if (cap_en) txlog.push_back(uart_tx);
  end

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] rr;
    logic        exp_we;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [11];

  // Behavioural model state for the random phase
  logic [LW-1:0]  m_led;
  logic [31:0]    m_timer;
  logic [SWW-1:0] m_s1, m_s2;

  initial begin
    logic [7:0]  bytes [9];
    logic [7:0]  got [$];
    int          starts [$];
    logic [7:0]  b;
    logic [31:0] exp_rd, tv;
    logic        exp_bit, exp_irq, drained, wr_led, wr_tim;
    int          i, kind, j;
    logic [11:0] off;

    sw = '0;
    ram_rdata = 32'h0;
    do_reset();

    // Reset state
    check("rst_led", 32'(led), 32'h0);
    check("rst_uart_tx", 32'(uart_tx), 32'h1);
    check("rst_timer_irq", 32'(timer_irq), 32'h0);

    // Decode table (no MMIO writes, so MMIO values stay at reset)
    tbl[0]  = '{32'h0000_0040, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    tbl[1]  = '{32'h0000_0040, 1'b1, 32'h1111_2222, 1'b0, 32'h1111_2222};
    tbl[2]  = '{32'hFFFF_EFFC, 1'b0, 32'hCAFE_0001, 1'b1, 32'hCAFE_0001};
    tbl[3]  = '{32'hFFFF_F000, 1'b1, 32'h5555_5555, 1'b0, 32'h0};
    tbl[4]  = '{32'hFFFF_F004, 1'b1, 32'h5555_5555, 1'b0, 32'h0};
    tbl[5]  = '{32'hFFFF_F00C, 1'b1, 32'h5555_5555, 1'b0, 32'h0};
    tbl[6]  = '{32'hFFFF_F010, 1'b1, 32'h5555_5555, 1'b0, 32'h2};
    tbl[7]  = '{32'hFFFF_F100, 1'b1, 32'h5555_5555, 1'b0, 32'h0};
    tbl[8]  = '{32'hFFFF_FFFC, 1'b1, 32'h5555_5555, 1'b0, 32'h0};
    tbl[9]  = '{32'h7FFF_F000, 1'b0, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D};
    tbl[10] = '{32'hFFFF_F018, 1'b1, 32'hAAAA_AAAA, 1'b0, 32'h0};
    for (int k = 0; k < 11; k++) begin
      dmem_addr  = tbl[k].addr;
      dmem_wen   = tbl[k].wen;
      ram_rdata  = tbl[k].rr;
      dmem_wdata = $urandom;
      #1;
      check($sformatf("tbl%0d_ram_we", k), 32'(ram_we), 32'(tbl[k].exp_we));
      check($sformatf("tbl%0d_rdata", k), dmem_rdata, tbl[k].exp_rd);
      check($sformatf("tbl%0d_ram_addr", k), ram_addr, tbl[k].addr);
    end
    idle();
    tick();

    // RAM store passthrough and LED store
    dmem_addr = 32'h0000_0040; dmem_wdata = 32'h1234_5678; mask = 2'b10; dmem_wen = 1'b0;
    #1;
    check("ram_store_we", 32'(ram_we), 32'h1);
    check("ram_store_wdata", ram_wdata, 32'h1234_5678);
    check("ram_store_mask", 32'(ram_mask), 32'h2);
    dmem_addr = MM; dmem_wdata = 32'h0000_5678;
    #1;
    check("led_store_we", 32'(ram_we), 32'h0);
    tick();
    idle();
    check("led_value", 32'(led), 32'h5678);

    // Timer counts cycles since reset, then load and wrap
    do_reset();
    dmem_addr = MM | 32'h008;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("timer_n%0d", k), dmem_rdata, 32'(k));
      tick();
    end
    mmio_write(12'h008, 32'hFFFF_FFFE);
    dmem_addr = MM | 32'h008;
    #1;
    check("timer_load", dmem_rdata, 32'hFFFF_FFFF);
    tick();
    check("timer_wrap", dmem_rdata, 32'h0);

    // Single UART frame, sampled each cycle
    do_reset();
    mmio_write(12'h00C, 32'h0000_00A5);
    #1;
    check("uart_pre_tx", 32'(uart_tx), 32'h1);
    check("uart_pre_stat", dmem_rdata, stat_word(0, 0, 0, 0, 1));
    for (int k = 0; k < 40; k++) begin
      tick();
      j = k / 4;
      if (j == 0)      exp_bit = 1'b0;
      else if (j == 9) exp_bit = 1'b1;
      else             exp_bit = (8'hA5 >> (j - 1)) & 8'h01 ? 1'b1 : 1'b0;
      check($sformatf("uart_bit_c%0d", k), 32'(uart_tx), 32'(exp_bit));
      if (k == 0) check("uart_busy_stat", dmem_rdata, stat_word(0, 1, 1, 0, 0));
    end
    tick();
    check("uart_post_tx", 32'(uart_tx), 32'h1);
    check("uart_post_stat", dmem_rdata, stat_word(0, 1, 0, 0, 0));

    // FIFO overflow and back-to-back frames
    do_reset();
    txlog.delete();
    cap_en = 1'b1;
    bytes[0] = 8'h3C;
    mmio_write(12'h00C, 32'(bytes[0]));
    tick();
    for (int k = 1; k <= 8; k++) bytes[k] = 8'($urandom);
    for (int k = 0; k < 9; k++) begin
      dmem_addr = MM | 32'h00C;
      dmem_wen  = 1'b0;
      dmem_wdata = (k < 8) ? 32'(bytes[k + 1]) : 32'h0000_00EE;
      tick();
    end
    idle();
    #1;
    check("ovf_stat", dmem_rdata, stat_word(1, 0, 1, 1, 8));
    mmio_write(12'h010, 32'h0);
    #1;
    check("ovf_clear_stat", dmem_rdata, stat_word(1, 0, 1, 0, 8));
    drained = 1'b0;
    for (int k = 0; k < 2000 && !drained; k++) begin
      tick();
      if (dmem_rdata == stat_word(0, 1, 0, 0, 0)) drained = 1'b1;
    end
    check("drain_done", 32'(drained), 32'h1);
    repeat (4) tick();
    cap_en = 1'b0;
    got.delete();
    starts.delete();
    i = 0;
    while (i + 40 <= txlog.size()) begin
      if (txlog[i] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = txlog[i + 4 * (k + 1) + 2];
        check("frame_stop_bit", 32'(txlog[i + 38]), 32'h1);
        got.push_back(b);
        starts.push_back(i);
        i += 40;
      end else begin
        i++;
      end
    end
    check("frame_count", 32'(got.size()), 32'd9);
    for (int k = 0; k < 9 && k < got.size(); k++) begin
      check($sformatf("frame%0d_byte", k), 32'(got[k]), 32'(bytes[k]));
      if (k > 0) check($sformatf("frame%0d_gap", k), 32'(starts[k] - starts[k - 1]), 32'd41);
    end

    // Switch synchroniser latency and unmapped read
    dmem_addr = MM | 32'h004;
    tick();
    sw = 16'hBEEF;
    #1;
    check("sw_edgeK", dmem_rdata, 32'h0);
    tick();
    check("sw_edgeK1", dmem_rdata, 32'h0);
    tick();
    check("sw_edgeK2", dmem_rdata, 32'h0000_BEEF);
    dmem_addr = MM | 32'h100;
    #1;
    check("unmapped_100", dmem_rdata, 32'h0);
    sw = '0;

    // Reset during DATA aborts frame and empties FIFO
    do_reset();
    mmio_write(12'h00C, 32'h5A);
    mmio_write(12'h00C, 32'h33);
    repeat (12) tick();
    #1;
    check("midframe_busy", dmem_rdata, stat_word(0, 0, 1, 0, 1));
    do_reset();
    check("abort_tx", 32'(uart_tx), 32'h1);
    check("abort_stat", dmem_rdata, stat_word(0, 1, 0, 0, 0));
    repeat (3) tick();
    check("abort_tx_hold", 32'(uart_tx), 32'h1);
    check("abort_stat_hold", dmem_rdata, stat_word(0, 1, 0, 0, 0));

`ifdef TIMER_CMP_EN
    // Compare interrupt
    do_reset();
    mmio_write(12'h014, 32'd20);
    dmem_addr = MM | 32'h014;
    #1;
    check("cmp_readback", dmem_rdata, 32'd20);
    dmem_addr = MM | 32'h008;
    exp_irq = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      check($sformatf("irq_c%0d", k), 32'(timer_irq), 32'(exp_irq));
      tv = dmem_rdata;
      tick();
      if (tv == 32'd20) exp_irq = 1'b1;
    end
    check("irq_held", 32'(timer_irq), 32'h1);
    mmio_write(12'h014, 32'd5000);
    check("irq_cleared", 32'(timer_irq), 32'h0);
`else
    mmio_write(12'h014, 32'd20);
    dmem_addr = MM | 32'h014;
    #1;
    check("cmp_absent_read", dmem_rdata, 32'h0);
    repeat (30) tick();
    check("irq_tied_low", 32'(timer_irq), 32'h0);
`endif

    // Randomized accesses vs model
    do_reset();
    m_led = '0; m_timer = '0; m_s1 = '0; m_s2 = '0;
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 6);
      dmem_wdata = $urandom;
      mask       = 2'($urandom_range(0, 2));
      dmem_wen   = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      ram_rdata  = $urandom;
      if ($urandom_range(0, 3) == 0) sw = SWW'($urandom);
      case (kind)
        0: begin
          dmem_addr = $urandom;
          if (dmem_addr[31:12] == 20'hFFFFF) dmem_addr[31] = 1'b0;
        end
        1: dmem_addr = MM | 32'h000;
        2: dmem_addr = MM | 32'h004;
        3: dmem_addr = MM | 32'h008;
        4: dmem_addr = MM | 32'h010;
        5: dmem_addr = MM | (32'h018 + 32'(4 * $urandom_range(0, 1000)));
        default: begin
          dmem_addr = MM | 32'h00C;
          dmem_wen  = 1'b1;
        end
      endcase
      off = dmem_addr[11:0];
      if (dmem_addr[31:12] != 20'hFFFFF) exp_rd = ram_rdata;
      else if (off == 12'h000)           exp_rd = 32'(m_led);
      else if (off == 12'h004)           exp_rd = 32'(m_s2);
      else if (off == 12'h008)           exp_rd = m_timer;
      else if (off == 12'h010)           exp_rd = stat_word(0, 1, 0, 0, 0);
      else                               exp_rd = 32'h0;
      #1;
      check("rnd_ram_we", 32'(ram_we), 32'((kind == 0) && !dmem_wen));
      check("rnd_rdata", dmem_rdata, exp_rd);
      wr_led = (kind == 1) && !dmem_wen;
      wr_tim = (kind == 3) && !dmem_wen;
      tick();
      if (wr_led) m_led = dmem_wdata[LW-1:0];
      m_timer = wr_tim ? dmem_wdata + 32'd1 : m_timer + 32'd1;
      m_s2 = m_s1;
      m_s1 = sw;
      check("rnd_led", 32'(led), 32'(m_led));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
